// File: rtl/cv32e40p_retire_tracer_if.sv
// cv32e40p_retire_tracer_if: valid/ready retire record port between the tracer and its consumer.
// trc_stall_o exists only when TRACER_STALL_CNT_EN is defined.
interface cv32e40p_retire_tracer_if #(parameter int SEQ_W = 16);
  logic             trc_valid_o;
  logic             trc_ready_i;
  logic [31:0]      trc_pc_o;
  logic [31:0]      trc_instr_o;
  logic             trc_we_o;
  logic [5:0]       trc_waddr_o;
  logic [31:0]      trc_wdata_o;
  logic [SEQ_W-1:0] trc_seq_o;
`ifdef TRACER_STALL_CNT_EN
  logic [7:0]       trc_stall_o;
`endif
  modport master (
    input  trc_ready_i,
    output trc_valid_o, trc_pc_o, trc_instr_o, trc_we_o, trc_waddr_o, trc_wdata_o, trc_seq_o
`ifdef TRACER_STALL_CNT_EN
    , trc_stall_o
`endif
  );
  modport slave (
    output trc_ready_i,
    input  trc_valid_o, trc_pc_o, trc_instr_o, trc_we_o, trc_waddr_o, trc_wdata_o, trc_seq_o
`ifdef TRACER_STALL_CNT_EN
    , trc_stall_o
`endif
  );
endinterface

// File: rtl/cv32e40p_retire_tracer.sv
// cv32e40p_retire_tracer: pairs ID->EX issues with EX retires and emits ordered retire records.
// Optional per-entry stall counter enabled by defining TRACER_STALL_CNT_EN.
module cv32e40p_retire_tracer #(
  parameter int ISS_DEPTH = 4,
  parameter int OUT_DEPTH = 8,
  parameter int SEQ_W     = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_valid_id_i,
  input  logic        id_ready_i,
  input  logic [31:0] pc_id_i,
  input  logic [31:0] instr_rdata_id_i,
  input  logic        ex_valid_i,
  input  logic        ex_ready_i,
  input  logic        wb_we_i,
  input  logic [5:0]  wb_waddr_i,
  input  logic [31:0] wb_wdata_i,
  input  logic        flush_i,
  cv32e40p_retire_tracer_if.master trc,
  output logic        iss_overflow_o,
  output logic        retire_orphan_o,
  output logic [15:0] drop_cnt_o
);
  localparam int IW = $clog2(ISS_DEPTH);
  localparam int OW = $clog2(OUT_DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
`ifdef TRACER_STALL_CNT_EN
    logic [7:0]  stall;
`endif
  } iss_t;

  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      instr;
    logic             we;
    logic [5:0]       waddr;
    logic [31:0]      wdata;
    logic [SEQ_W-1:0] seq;
`ifdef TRACER_STALL_CNT_EN
    logic [7:0]       stall;
`endif
  } rec_t;

  iss_t             iss_mem_q [ISS_DEPTH];
  iss_t             iss_mem_d [ISS_DEPTH];
  logic [IW-1:0]    iss_rd_q, iss_rd_d, iss_wr_q, iss_wr_d;
  logic [IW:0]      iss_cnt_q, iss_cnt_d;
  rec_t             out_mem_q [OUT_DEPTH];
  rec_t             out_mem_d [OUT_DEPTH];
  logic [OW-1:0]    out_rd_q, out_rd_d, out_wr_q, out_wr_d;
  logic [OW:0]      out_cnt_q, out_cnt_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic             ovf_q, ovf_d, orph_q, orph_d;
  logic [15:0]      drop_q, drop_d;
  logic             iss, ret, pop, push, out_pop, out_wr;
  iss_t             head;
  rec_t             rec, out_head;

  always_comb begin
    iss = instr_valid_id_i & id_ready_i;
    ret = ex_valid_i & ex_ready_i;
    pop = ret & (iss_cnt_q != '0);
    head = iss_mem_q[iss_rd_q];
    iss_mem_d = iss_mem_q;
`ifdef TRACER_STALL_CNT_EN
    for (int i = 0; i < ISS_DEPTH; i++)
      iss_mem_d[i].stall = iss_mem_q[i].stall + {7'd0, iss_mem_q[i].stall != 8'hFF};
`endif
    // order within a cycle: pop, then flush, then push
    iss_rd_d = flush_i ? iss_wr_q : iss_rd_q + IW'(pop);
    iss_cnt_d = flush_i ? '0 : iss_cnt_q - (IW+1)'(pop);
    push = iss & (iss_cnt_d != (IW+1)'(ISS_DEPTH));
    iss_wr_d = iss_wr_q + IW'(push);
    iss_cnt_d = iss_cnt_d + (IW+1)'(push);
    if (push) begin
      iss_mem_d[iss_wr_q].pc = pc_id_i;
      iss_mem_d[iss_wr_q].instr = instr_rdata_id_i;
`ifdef TRACER_STALL_CNT_EN
      iss_mem_d[iss_wr_q].stall = '0;
`endif
    end
    rec.pc = head.pc;
    rec.instr = head.instr;
    rec.we = wb_we_i;
    rec.waddr = wb_we_i ? wb_waddr_i : '0;
    rec.wdata = wb_we_i ? wb_wdata_i : '0;
    rec.seq = seq_q;
`ifdef TRACER_STALL_CNT_EN
    rec.stall = head.stall + {7'd0, head.stall != 8'hFF};
`endif
    out_pop = (out_cnt_q != '0) & trc.trc_ready_i;
    out_wr = pop & ((out_cnt_q != (OW+1)'(OUT_DEPTH)) | out_pop);
    out_mem_d = out_mem_q;
    if (out_wr) out_mem_d[out_wr_q] = rec;
    out_wr_d = out_wr_q + OW'(out_wr);
    out_rd_d = out_rd_q + OW'(out_pop);
    out_cnt_d = out_cnt_q + (OW+1)'(out_wr) - (OW+1)'(out_pop);
    seq_d = seq_q + SEQ_W'(pop);
    ovf_d = ovf_q | (iss & ~push);
    orph_d = orph_q | (ret & ~pop);
    drop_d = drop_q + {15'd0, pop & ~out_wr & (drop_q != 16'hFFFF)};
    out_head = (out_cnt_q != '0) ? out_mem_q[out_rd_q] : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      iss_mem_q <= '{default: '0};
      iss_rd_q <= '0;
      iss_wr_q <= '0;
      iss_cnt_q <= '0;
      out_mem_q <= '{default: '0};
      out_rd_q <= '0;
      out_wr_q <= '0;
      out_cnt_q <= '0;
      seq_q <= '0;
      ovf_q <= 1'b0;
      orph_q <= 1'b0;
      drop_q <= '0;
    end else begin
      iss_mem_q <= iss_mem_d;
      iss_rd_q <= iss_rd_d;
      iss_wr_q <= iss_wr_d;
      iss_cnt_q <= iss_cnt_d;
      out_mem_q <= out_mem_d;
      out_rd_q <= out_rd_d;
      out_wr_q <= out_wr_d;
      out_cnt_q <= out_cnt_d;
      seq_q <= seq_d;
      ovf_q <= ovf_d;
      orph_q <= orph_d;
      drop_q <= drop_d;
    end
  end

  assign trc.trc_valid_o = out_cnt_q != '0;
  assign trc.trc_pc_o = out_head.pc;
  assign trc.trc_instr_o = out_head.instr;
  assign trc.trc_we_o = out_head.we;
  assign trc.trc_waddr_o = out_head.waddr;
  assign trc.trc_wdata_o = out_head.wdata;
  assign trc.trc_seq_o = out_head.seq;
`ifdef TRACER_STALL_CNT_EN
  assign trc.trc_stall_o = out_head.stall;
`endif
  assign iss_overflow_o = ovf_q;
  assign retire_orphan_o = orph_q;
  assign drop_cnt_o = drop_q;
endmodule

// File: tb/tb_cv32e40p_retire_tracer.sv
// tb_cv32e40p_retire_tracer: directed checks of issue/retire pairing, overflow, flush, drops and reset.
module tb_cv32e40p_retire_tracer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv, idr, exv, exr, we, flush;
  logic [31:0] pc, instr, wdata;
  logic [5:0]  waddr;
  logic        ovf, orph;
  logic [15:0] drop;
  int          tests = 0;
  int          fails = 0;

  cv32e40p_retire_tracer_if #(.SEQ_W(16)) trc ();

  cv32e40p_retire_tracer dut (
    .clk_i(clk), .rst_i(rst),
    .instr_valid_id_i(iv), .id_ready_i(idr), .pc_id_i(pc), .instr_rdata_id_i(instr),
    .ex_valid_i(exv), .ex_ready_i(exr),
    .wb_we_i(we), .wb_waddr_i(waddr), .wb_wdata_i(wdata),
    .flush_i(flush), .trc(trc.master),
    .iss_overflow_o(ovf), .retire_orphan_o(orph), .drop_cnt_o(drop)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    iv = 0; idr = 0; exv = 0; exr = 0; we = 0; flush = 0;
    pc = 0; instr = 0; wdata = 0; waddr = 0;
    trc.trc_ready_i = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic issue(input logic [31:0] p, input logic [31:0] ins);
    iv = 1; idr = 1; pc = p; instr = ins;
    tick();
    iv = 0; idr = 0; pc = 0; instr = 0;
  endtask

  task automatic retire(input logic w, input logic [5:0] a, input logic [31:0] d);
    exv = 1; exr = 1; we = w; waddr = a; wdata = d;
    tick();
    exv = 0; exr = 0; we = 0; waddr = 0; wdata = 0;
  endtask

  task automatic get_rec(input string tag, input logic [31:0] p, input logic [31:0] s,
                         input logic w, input logic [5:0] a, input logic [31:0] d);
    chk({tag, "_valid"}, {31'd0, trc.trc_valid_o}, 1);
    chk({tag, "_pc"}, trc.trc_pc_o, p);
    chk({tag, "_seq"}, {16'd0, trc.trc_seq_o}, s);
    chk({tag, "_we"}, {31'd0, trc.trc_we_o}, {31'd0, w});
    chk({tag, "_waddr"}, {26'd0, trc.trc_waddr_o}, {26'd0, a});
    chk({tag, "_wdata"}, trc.trc_wdata_o, d);
    trc.trc_ready_i = 1;
    tick();
    trc.trc_ready_i = 0;
  endtask

  initial begin
    do_reset();
    chk("rst_valid", {31'd0, trc.trc_valid_o}, 0);
    chk("rst_pc", trc.trc_pc_o, 0);
    chk("rst_seq", {16'd0, trc.trc_seq_o}, 0);
    chk("rst_ovf", {31'd0, ovf}, 0);
    chk("rst_orph", {31'd0, orph}, 0);
    chk("rst_drop", {16'd0, drop}, 0);

    // basic issue -> retire -> record one cycle later
    issue(32'h80, 32'h00500093);
    tick();
    retire(1, 6'd1, 32'd5);
    chk("basic_instr", trc.trc_instr_o, 32'h00500093);
    get_rec("basic", 32'h80, 0, 1, 6'd1, 32'd5);
    chk("basic_empty", {31'd0, trc.trc_valid_o}, 0);
    chk("basic_empty_pc", trc.trc_pc_o, 0);

    // overflow of the issue queue, then ordered retires with writeback disabled
    do_reset();
    for (int i = 0; i < 5; i++) begin
      issue(32'h100 + 32'(4 * i), 32'h13);
      if (i == 3) chk("ovf_before", {31'd0, ovf}, 0);
    end
    chk("ovf_set", {31'd0, ovf}, 1);
    for (int i = 0; i < 4; i++) retire(0, 6'd3, 32'hDEAD);
    for (int i = 0; i < 4; i++) get_rec("ovf_rec", 32'h100 + 32'(4 * i), 32'(i), 0, 6'd0, 32'd0);
    chk("ovf_drained", {31'd0, trc.trc_valid_o}, 0);
    chk("ovf_no_orph", {31'd0, orph}, 0);
    // issue and retire together on a full queue
    for (int i = 0; i < 4; i++) issue(32'h120 + 32'(4 * i), 32'h13);
    iv = 1; idr = 1; pc = 32'h130;
    retire(1, 6'd9, 32'h99);
    iv = 0; idr = 0; pc = 0;
    get_rec("full_both", 32'h120, 4, 1, 6'd9, 32'h99);
    for (int i = 0; i < 4; i++) retire(0, 6'd0, 32'd0);
    for (int i = 0; i < 4; i++) get_rec("full_rest", 32'h124 + 32'(4 * i), 32'(5 + i), 0, 6'd0, 32'd0);

    // orphan retire
    do_reset();
    retire(1, 6'd2, 32'h2);
    chk("orph_novalid", {31'd0, trc.trc_valid_o}, 0);
    chk("orph_set", {31'd0, orph}, 1);
    issue(32'h180, 32'h33);
    retire(1, 6'd4, 32'h44);
    get_rec("orph_next", 32'h180, 0, 1, 6'd4, 32'h44);

    // flush with a same-cycle retire
    do_reset();
    for (int i = 0; i < 3; i++) issue(32'h200 + 32'(4 * i), 32'h13);
    flush = 1;
    retire(1, 6'd7, 32'h77);
    flush = 0;
    get_rec("flush_rec", 32'h200, 0, 1, 6'd7, 32'h77);
    chk("flush_one", {31'd0, trc.trc_valid_o}, 0);
    chk("flush_orph_before", {31'd0, orph}, 0);
    retire(0, 6'd0, 32'd0);
    chk("flush_orph", {31'd0, orph}, 1);
    chk("flush_norec", {31'd0, trc.trc_valid_o}, 0);
    // flush with a same-cycle issue keeps the issue
    issue(32'h2F0, 32'h13);
    flush = 1;
    issue(32'h300, 32'h13);
    flush = 0;
    retire(0, 6'd0, 32'd0);
    get_rec("flush_keep", 32'h300, 1, 0, 6'd0, 32'd0);

    // output FIFO overflow drops records but seq keeps counting
    do_reset();
    for (int i = 0; i <= 10; i++) begin
      iv = (i < 10); idr = (i < 10); pc = 32'h400 + 32'(4 * i);
      exv = (i > 0); exr = (i > 0);
      tick();
    end
    idle();
    chk("drop_cnt", {16'd0, drop}, 2);
    for (int i = 0; i < 8; i++) get_rec("drop_rec", 32'h400 + 32'(4 * i), 32'(i), 0, 6'd0, 32'd0);
    chk("drop_drained", {31'd0, trc.trc_valid_o}, 0);
    issue(32'h500, 32'h13);
    retire(1, 6'd11, 32'hB);
    get_rec("drop_next", 32'h500, 10, 1, 6'd11, 32'hB);

    // reset mid-operation
    do_reset();
    for (int i = 0; i < 5; i++) issue(32'h600 + 32'(4 * i), 32'h13);
    retire(0, 6'd0, 32'd0);
    retire(0, 6'd0, 32'd0);
    chk("mid_valid_before", {31'd0, trc.trc_valid_o}, 1);
    chk("mid_ovf_before", {31'd0, ovf}, 1);
    rst = 1;
    tick();
    rst = 0;
    chk("mid_valid", {31'd0, trc.trc_valid_o}, 0);
    chk("mid_drop", {16'd0, drop}, 0);
    chk("mid_ovf", {31'd0, ovf}, 0);
    chk("mid_orph", {31'd0, orph}, 0);
    retire(0, 6'd0, 32'd0);
    chk("mid_queue_empty", {31'd0, orph}, 1);
    issue(32'h700, 32'h13);
    retire(1, 6'd5, 32'h55);
    get_rec("mid_next", 32'h700, 0, 1, 6'd5, 32'h55);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
